// File: rtl/cpu_pkg.sv
// Shared widths, the zero-register index and the NZVC flag type for the CPU pipeline.
package cpu_pkg;
  localparam int DATA_W = 64;
  localparam int REG_W  = 5;
  localparam int XZR    = 31;

  typedef struct packed {
    logic n;
    logic z;
    logic v;
    logic c;
  } flags_t;
endpackage

// File: rtl/flag_reg.sv
// Architectural NZVC register: loads on enable, clears asynchronously on reset.
module flag_reg (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] d,
  output logic [3:0] q
);
  import cpu_pkg::*;

  flags_t r;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     r <= '0;
    else if (load) r <= d;
  end

  assign q = r;
endmodule

// File: rtl/exe_mem_stage.sv
// EX/MEM pipeline register with NZVC flag register and MEM->EX forwarding source.
// Define FLAG_BYPASS_EN to bypass fresh ALU flags onto flags_cond in the same cycle.
module exe_mem_stage #(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int REG_W  = cpu_pkg::REG_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ex_result,
  input  logic              ex_negative,
  input  logic              ex_zero,
  input  logic              ex_overflow,
  input  logic              ex_carry,
  input  logic              ex_set_flags,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic [REG_W-1:0]  ex_rd,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic              stall,
  input  logic              flush,
  output logic              mem_valid,
  output logic [DATA_W-1:0] mem_result,
  output logic [DATA_W-1:0] mem_store_data,
  output logic [REG_W-1:0]  mem_rd,
  output logic              mem_reg_write,
  output logic              mem_mem_read,
  output logic              mem_mem_write,
  output logic [3:0]        flags_q,
  output logic [3:0]        flags_cond,
  output logic              fwd_en,
  output logic [REG_W-1:0]  fwd_rd,
  output logic [DATA_W-1:0] fwd_data
);
  import cpu_pkg::*;

  flags_t ex_flags;
  logic   advance;
  logic   flags_load;

  assign ex_flags   = {ex_negative, ex_zero, ex_overflow, ex_carry};
  assign advance    = !flush && !stall;
  assign flags_load = advance && ex_valid && ex_set_flags;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_valid      <= 1'b0;
      mem_reg_write  <= 1'b0;
      mem_mem_read   <= 1'b0;
      mem_mem_write  <= 1'b0;
      mem_rd         <= '0;
      mem_result     <= '0;
      mem_store_data <= '0;
    end else if (flush) begin
      // Squash only kills control; data fields are dead behind mem_valid=0.
      mem_valid      <= 1'b0;
      mem_reg_write  <= 1'b0;
      mem_mem_read   <= 1'b0;
      mem_mem_write  <= 1'b0;
    end else if (!stall) begin
      mem_valid      <= ex_valid;
      mem_reg_write  <= ex_valid && ex_reg_write && (ex_rd != REG_W'(XZR));
      mem_mem_read   <= ex_valid && ex_mem_read;
      mem_mem_write  <= ex_valid && ex_mem_write;
      mem_rd         <= ex_rd;
      mem_result     <= ex_result;
      mem_store_data <= ex_store_data;
    end
  end

  flag_reg u_flag_reg (
    .clk   (clk),
    .reset (reset),
    .load  (flags_load),
    .d     (ex_flags),
    .q     (flags_q)
  );

`ifdef FLAG_BYPASS_EN
  assign flags_cond = (ex_valid && ex_set_flags && !flush) ? ex_flags : flags_q;
`else
  // Hazard unit stalls a flag consumer one cycle, so the register alone suffices.
  assign flags_cond = flags_q;
`endif

  assign fwd_en   = mem_valid && mem_reg_write;
  assign fwd_rd   = mem_rd;
  assign fwd_data = mem_result;

  // Load and store in one instruction is a decode bug; it is captured as-is.
  a_rw_excl: assert property (@(posedge clk) disable iff (reset)
    !(ex_valid && ex_mem_read && ex_mem_write));
endmodule

// File: tb/tb_exe_mem_stage.sv
// Directed corner cases plus a randomized run checked by a queue-based scoreboard.
module tb_exe_mem_stage;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ex_valid = 0, ex_negative = 0, ex_zero = 0, ex_overflow = 0, ex_carry = 0;
  logic        ex_set_flags = 0, ex_reg_write = 0, ex_mem_read = 0, ex_mem_write = 0;
  logic        stall = 0, flush = 0;
  logic [63:0] ex_result = '0, ex_store_data = '0;
  logic [4:0]  ex_rd = '0;
  logic        mem_valid, mem_reg_write, mem_mem_read, mem_mem_write, fwd_en;
  logic [63:0] mem_result, mem_store_data, fwd_data;
  logic [4:0]  mem_rd, fwd_rd;
  logic [3:0]  flags_q, flags_cond;

  int errors = 0;
  int checks = 0;

  exe_mem_stage #(.DATA_W(64), .REG_W(5)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_result(ex_result),
    .ex_negative(ex_negative), .ex_zero(ex_zero), .ex_overflow(ex_overflow), .ex_carry(ex_carry),
    .ex_set_flags(ex_set_flags), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .stall(stall), .flush(flush), .mem_valid(mem_valid), .mem_result(mem_result),
    .mem_store_data(mem_store_data), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write), .flags_q(flags_q),
    .flags_cond(flags_cond), .fwd_en(fwd_en), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v, rw, mr, mw;
    logic [4:0]  rd;
    logic [63:0] res, sd;
    logic [3:0]  fl;
  } st_t;

  st_t exp_q[$];
  st_t model;
  bit  drv_done = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Architectural behaviour of one clock edge given the inputs now on the EX side.
  function automatic st_t next_state(input st_t s);
    st_t n = s;
    if (flush) begin
      n.v = 0; n.rw = 0; n.mr = 0; n.mw = 0;
    end else if (!stall) begin
      n.v  = ex_valid;
      n.rw = ex_valid && ex_reg_write && (ex_rd != 5'd31);
      n.mr = ex_valid && ex_mem_read;
      n.mw = ex_valid && ex_mem_write;
      n.rd = ex_rd; n.res = ex_result; n.sd = ex_store_data;
      if (ex_valid && ex_set_flags) n.fl = {ex_negative, ex_zero, ex_overflow, ex_carry};
    end
    return n;
  endfunction

  function automatic logic [3:0] cond_expect(input logic [3:0] fq);
`ifdef FLAG_BYPASS_EN
    if (ex_valid && ex_set_flags && !flush) return {ex_negative, ex_zero, ex_overflow, ex_carry};
`endif
    return fq;
  endfunction

  task automatic randomize_ex();
    int k;
    ex_valid      = ($urandom_range(0, 9) < 8);
    ex_result     = {$urandom, $urandom};
    ex_store_data = {$urandom, $urandom};
    ex_rd         = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
    ex_reg_write  = $urandom_range(0, 1);
    k             = $urandom_range(0, 2);
    ex_mem_read   = (k == 1);
    ex_mem_write  = (k == 2);
    {ex_negative, ex_zero, ex_overflow, ex_carry} = 4'($urandom);
    ex_set_flags  = $urandom_range(0, 1);
    stall         = ($urandom_range(0, 4) == 0);
    flush         = ($urandom_range(0, 9) == 0);
  endtask

  initial begin : main
    logic [63:0] held_res;
    logic [3:0]  held_fl;
    // Reset state, before any clock edge.
    #3;
    chk("reset_valid", mem_valid, 0);
    chk("reset_flags", flags_q, 0);
    chk("reset_result", mem_result, 0);
    chk("reset_fwd_en", fwd_en, 0);
    #9 reset = 0;

    // Simple ALU result to x3 is forwarded the next cycle.
    ex_valid = 1; ex_result = 64'h00FA; ex_rd = 3; ex_reg_write = 1;
    step();
    chk("adv_valid", mem_valid, 1);
    chk("adv_result", mem_result, 64'h00FA);
    chk("adv_fwd_en", fwd_en, 1);
    chk("adv_fwd_rd", fwd_rd, 3);
    chk("adv_fwd_data", fwd_data, 64'h00FA);

    // Writes to XZR are dropped.
    ex_rd = 31;
    step();
    chk("xzr_reg_write", mem_reg_write, 0);
    chk("xzr_fwd_en", fwd_en, 0);

    // SUBS 2-4 sets N; a following plain ADD leaves the flags alone.
    ex_rd = 4; ex_result = 64'hFFFF_FFFF_FFFF_FFFE; ex_set_flags = 1;
    {ex_negative, ex_zero, ex_overflow, ex_carry} = 4'b1000;
    step();
    chk("subs_flags", flags_q, 4'b1000);
    ex_set_flags = 0; ex_result = 64'h6;
    {ex_negative, ex_zero, ex_overflow, ex_carry} = 4'b0111;
    step();
    chk("add_keeps_flags", flags_q, 4'b1000);

    // Zero flag visibility on flags_cond before and after the edge.
    ex_set_flags = 1; {ex_negative, ex_zero, ex_overflow, ex_carry} = 4'b0100;
    #1;
`ifdef FLAG_BYPASS_EN
    chk("bypass_z_same_cycle", flags_cond[2], 1);
`else
    chk("nobypass_z_same_cycle", flags_cond[2], 0);
`endif
    step();
    chk("z_after_edge", flags_cond[2], 1);
    chk("z_flags_q", flags_q, 4'b0100);

    // Three stalled cycles with churning EX inputs hold everything.
    held_res = mem_result; held_fl = flags_q;
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      ex_result = {$urandom, $urandom}; ex_set_flags = 1;
      {ex_negative, ex_zero, ex_overflow, ex_carry} = 4'b1011;
      step();
      chk("stall_result", mem_result, held_res);
      chk("stall_flags", flags_q, held_fl);
      chk("stall_valid", mem_valid, 1);
    end
    flush = 1;
    step();
    chk("stall_flush_valid", mem_valid, 0);
    chk("stall_flush_fwd_en", fwd_en, 0);
    chk("stall_flush_flags", flags_q, held_fl);

    // Reset in the middle of a stall+flush cycle with a live MEM entry.
    stall = 0; flush = 0; ex_set_flags = 0; ex_result = 64'h1234; ex_rd = 7;
    step();
    chk("pre_reset_valid", mem_valid, 1);
    stall = 1; flush = 1;
    #2 reset = 1;
    #1;
    chk("midrst_valid", mem_valid, 0);
    chk("midrst_result", mem_result, 0);
    chk("midrst_rd", mem_rd, 0);
    chk("midrst_store", mem_store_data, 0);
    chk("midrst_flags", flags_q, 0);
    chk("midrst_fwd_en", fwd_en, 0);
    #1 reset = 0;
    stall = 0; flush = 0; ex_result = 64'hBEEF; ex_rd = 9; ex_store_data = 64'h55;
    step();
    chk("post_rst_valid", mem_valid, 1);
    chk("post_rst_result", mem_result, 64'hBEEF);
    chk("post_rst_store", mem_store_data, 64'h55);
    chk("post_rst_fwd_rd", fwd_rd, 9);

    // Randomized run from a clean reset.
    reset = 1; #2 reset = 0;
    model = '{v:0, rw:0, mr:0, mw:0, rd:0, res:0, sd:0, fl:0};
    ex_valid = 0; stall = 0; flush = 0;
    fork
      begin : driver
        st_t pending;
        bit  have = 0;
        for (int c = 0; c < 400; c++) begin
          @(posedge clk); #1;
          if (have) exp_q.push_back(pending);
          randomize_ex();
          pending = next_state(model);
          model = pending;
          have = 1;
        end
        @(posedge clk); #1;
        exp_q.push_back(pending);
        ex_valid = 0; stall = 0; flush = 0;
        drv_done = 1;
      end
      begin : monitor
        st_t e;
        int  budget = 1000;
        while (!(drv_done && exp_q.size() == 0) && budget > 0) begin
          @(posedge clk); #2;
          budget--;
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("sb_valid", mem_valid, e.v);
            chk("sb_reg_write", mem_reg_write, e.rw);
            chk("sb_mem_read", mem_mem_read, e.mr);
            chk("sb_mem_write", mem_mem_write, e.mw);
            chk("sb_flags_q", flags_q, e.fl);
            chk("sb_fwd_en", fwd_en, e.v & e.rw);
            chk("sb_flags_cond", flags_cond, cond_expect(e.fl));
            if (e.v) begin
              chk("sb_rd", mem_rd, e.rd);
              chk("sb_result", mem_result, e.res);
              chk("sb_store", mem_store_data, e.sd);
              chk("sb_fwd_data", fwd_data, e.res);
            end
          end
        end
        if (budget == 0) begin
          errors++; checks++;
          $display("FAIL sb_timeout: got pending=%0d expected 0", exp_q.size());
        end
      end
    join

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
